// File: rtl/subtr_8.sv
`default_nettype none
// ============================================================================
// Module   : subtr_8 (with half_subtr, full_subtr cells)
// Purpose  : Registered 8-bit ripple-borrow subtractor, {bout,diff} = a-b-bin.
//            Optional zero/neg/ovf flags enabled by macro SUBTR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================

module half_subtr (
   input  logic x,
   input  logic y,
   output logic d,
   output logic br
);
   assign d  = x ^ y;
   assign br = ~x & y;
endmodule

module full_subtr (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   logic w_d0;
   logic w_b0;
   logic w_b1;

   // Second stage subtracts the incoming borrow from the partial difference,
   // so its borrow is ~(x^y) & bi.
   half_subtr u_hs0 (.x(x),    .y(y),  .d(w_d0), .br(w_b0));
   half_subtr u_hs1 (.x(w_d0), .y(bi), .d(d),    .br(w_b1));

   assign bo = w_b0 | w_b1;
endmodule

module subtr_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUBTR_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   w_borrow;
   logic [WIDTH-1:0] w_diff;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   assign w_borrow[0] = bin;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         full_subtr u_fs (
            .x  (a[i]),
            .y  (b[i]),
            .bi (w_borrow[i]),
            .d  (w_diff[i]),
            .bo (w_borrow[i+1])
         );
      end
   endgenerate

   // Result registers hold their value on idle cycles; only out_valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_diff <= w_diff;
            r_bout <= w_borrow[WIDTH];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;

`ifdef SUBTR_FLAGS_EN
   logic w_zero;
   logic w_neg;
   logic w_ovf;
   logic r_zero;
   logic r_neg;
   logic r_ovf;

   // Signed overflow: operand signs differ and the result sign departs from a.
   assign w_zero = (w_diff == '0);
   assign w_neg  = w_diff[WIDTH-1];
   assign w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (in_valid) begin
         r_zero <= w_zero;
         r_neg  <= w_neg;
         r_ovf  <= w_ovf;
      end
   end

   assign zero = r_zero;
   assign neg  = r_neg;
   assign ovf  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_subtr_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtr_8
// Purpose  : Directed self-checking bench for subtr_8 and its subtractor cells.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_subtr_8;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       out_valid;
   logic [7:0] diff;
   logic       bout;
`ifdef SUBTR_FLAGS_EN
   logic       zero;
   logic       neg;
   logic       ovf;
`endif

   logic hx, hy, hd, hbr;
   logic fx, fy, fbi, fd, fbo;

   int n_cmp = 0;
   int n_bad = 0;

   subtr_8 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .diff      (diff),
      .bout      (bout)
`ifdef SUBTR_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
`endif
   );

   half_subtr u_hs (.x(hx), .y(hy), .d(hd), .br(hbr));
   full_subtr u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       z;
      logic       n;
      logic       v;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic bi);
      @(negedge clk);
      in_valid = v;
      a        = aa;
      b        = bb;
      bin      = bi;
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " diff"},      {24'd0, diff},      32'd0);
      check({tag, " bout"},      {31'd0, bout},      32'd0);
`ifdef SUBTR_FLAGS_EN
      check({tag, " flags"},     {29'd0, zero, neg, ovf}, 32'd0);
`endif
   endtask

   initial begin
      logic [1:0] hs_exp [4];
      logic [8:0] fdiff;
      hs_exp[0] = 2'b00; hs_exp[1] = 2'b11; hs_exp[2] = 2'b10; hs_exp[3] = 2'b00;

      //          a      b      bin   d      bo    z     n     v
      vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{8'h3C, 8'h1E, 1'b1, 8'h1D, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
      hx = 1'b0; hy = 1'b0; fx = 1'b0; fy = 1'b0; fbi = 1'b0;

      // Cells, exhaustive
      for (int i = 0; i < 4; i++) begin
         {hx, hy} = i[1:0];
         #1;
         check($sformatf("half_subtr xy=%0d", i), {30'd0, hd, hbr}, {30'd0, hs_exp[i]});
      end
      for (int i = 0; i < 8; i++) begin
         {fx, fy, fbi} = i[2:0];
         #1;
         fdiff = {8'd0, fx} - {8'd0, fy} - {8'd0, fbi};
         check($sformatf("full_subtr xybi=%0d", i), {30'd0, fd, fbo},
               {30'd0, fdiff[0], fdiff[8]});
      end

      // Asynchronous reset before any clock edge with rst high
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_cleared("reset_async");
      drive(1'b1, 8'h55, 8'h11, 1'b0);
      check_cleared("reset_held");
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;

      // Back-to-back vector table
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
         check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d diff", i),      {24'd0, diff},      {24'd0, vecs[i].d});
         check($sformatf("vec%0d bout", i),      {31'd0, bout},      {31'd0, vecs[i].bo});
`ifdef SUBTR_FLAGS_EN
         check($sformatf("vec%0d flags", i), {29'd0, zero, neg, ovf},
               {29'd0, vecs[i].z, vecs[i].n, vecs[i].v});
`endif
      end

      // Handshake 1,1,0,1 with result held during the idle cycle
      drive(1'b1, 8'h05, 8'h03, 1'b0);
      check("hs0 valid", {31'd0, out_valid}, 32'd1);
      check("hs0 diff",  {24'd0, diff},      32'h02);
      drive(1'b1, 8'h09, 8'h01, 1'b0);
      check("hs1 valid", {31'd0, out_valid}, 32'd1);
      check("hs1 diff",  {24'd0, diff},      32'h08);
      drive(1'b0, 8'h01, 8'h02, 1'b0);
      check("hs2 valid", {31'd0, out_valid}, 32'd0);
      check("hs2 diff held", {24'd0, diff},  32'h08);
      check("hs2 bout held", {31'd0, bout},  32'd0);
      drive(1'b1, 8'h20, 8'h10, 1'b0);
      check("hs3 valid", {31'd0, out_valid}, 32'd1);
      check("hs3 diff",  {24'd0, diff},      32'h10);

      // Mid-stream asynchronous reset discards the in-flight operand
      drive(1'b1, 8'h44, 8'h05, 1'b0);
      check("pre_rst diff", {24'd0, diff}, 32'h3F);
      @(negedge clk);
      in_valid = 1'b1; a = 8'h77; b = 8'h07; bin = 1'b0;
      #2 rst = 1'b1;
      #1 check_cleared("midrst_async");
      @(posedge clk);
      #1 check_cleared("midrst_edge");
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1 check("post_rst idle valid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 8'h12, 8'h02, 1'b0);
      check("post_rst valid", {31'd0, out_valid}, 32'd1);
      check("post_rst diff",  {24'd0, diff},      32'h10);
      check("post_rst bout",  {31'd0, bout},      32'd0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
